// File: rtl/inst_sequencer.sv
// rtl/inst_sequencer.sv - instruction word sequencer for kernel-tap passes and psum accumulation
module inst_sequencer #(
    parameter int col     = 8,
    parameter int row     = 8,
    parameter int len_nij = 36,
    parameter int len_kij = 9,
    parameter int gap     = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_kij,
    input  logic        start_acc,
    input  logic [3:0]  kij,
    input  logic [3:0]  onij,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_W_L0    = 4'd1;
    localparam logic [3:0] S_W_LD    = 4'd2;
    localparam logic [3:0] S_GAP     = 4'd3;
    localparam logic [3:0] S_A_L0    = 4'd4;
    localparam logic [3:0] S_EXEC    = 4'd5;
    localparam logic [3:0] S_OF_WAIT = 4'd6;
    localparam logic [3:0] S_OF_RD   = 4'd7;
    localparam logic [3:0] S_ACC     = 4'd8;

    localparam int          CW  = 7;
    localparam logic [33:0] NOP = 34'h1_800C_0000;

    logic [3:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    kij_r, kij_n, onij_r, onij_n;
    logic          done_n, err_n;
    logic [33:0]   inst_n;
    logic [10:0]   cnt11, a_rd, a_acc;

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        kij_n   = kij_r;
        onij_n  = onij_r;
        done_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                // start_kij has priority; a 4-bit onij can never be out of range
                if (start_kij) begin
                    if (kij <= 4'd8) begin
                        state_n = S_W_L0;
                        kij_n   = kij;
                    end else begin
                        err_n = 1'b1;
                    end
                end else if (start_acc) begin
                    state_n = S_ACC;
                    onij_n  = onij;
                end
            end
            S_W_L0: if (cnt == CW'(col)) begin
                state_n = S_W_LD;
                cnt_n   = '0;
            end
            S_W_LD: if (cnt == CW'(col - 1)) begin
                state_n = S_GAP;
                cnt_n   = '0;
            end
            S_GAP: if (cnt == CW'(gap - 1)) begin
                state_n = S_A_L0;
                cnt_n   = '0;
            end
            S_A_L0: if (cnt == CW'(len_nij)) begin
                state_n = S_EXEC;
                cnt_n   = '0;
            end
            S_EXEC: if (cnt == CW'(len_nij + row + col - 1)) begin
                state_n = S_OF_WAIT;
                cnt_n   = '0;
            end
            S_OF_WAIT: begin
                cnt_n = '0;
                if (ofifo_valid) state_n = S_OF_RD;
            end
            S_OF_RD: if (cnt == CW'(len_nij - 1)) begin
                state_n = S_IDLE;
                cnt_n   = '0;
                done_n  = 1'b1;
            end
            S_ACC: if (cnt == CW'(len_kij)) begin
                state_n = S_IDLE;
                cnt_n   = '0;
                done_n  = 1'b1;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Output pixel (r,c) under tap (kr,kc) reads input pixel (r+kr, c+kc) of the 6-wide map
    assign cnt11 = 11'(cnt_n);
    assign a_rd  = 11'(kij_n) * 11'(len_nij) + cnt11;
    assign a_acc = cnt11 * 11'(len_nij)
                 + (11'(onij_n[3:2]) + cnt11 / 11'd3) * 11'd6
                 + 11'(onij_n[1:0]) + cnt11 % 11'd3;

    always_comb begin
        inst_n = NOP;
        case (state_n)
            S_W_L0: begin
                inst_n[19]   = 1'b0;
                inst_n[17:7] = 11'h400 + cnt11;
                inst_n[2]    = (cnt_n != '0);
            end
            S_W_LD: begin
                inst_n[3] = 1'b1;
                inst_n[0] = 1'b1;
            end
            S_A_L0: begin
                inst_n[19]   = 1'b0;
                inst_n[17:7] = cnt11;
                inst_n[2]    = (cnt_n != '0);
            end
            S_EXEC: begin
                inst_n[1] = 1'b1;
                inst_n[3] = (cnt_n < CW'(len_nij));
            end
            S_OF_RD: begin
                inst_n[6]     = 1'b1;
                inst_n[32]    = 1'b0;
                inst_n[31]    = 1'b0;
                inst_n[30:20] = a_rd;
            end
            S_ACC: begin
                inst_n[33] = (cnt_n != '0);
                if (cnt_n < CW'(len_kij)) begin
                    inst_n[32]    = 1'b0;
                    inst_n[30:20] = a_acc;
                end
            end
            default: inst_n = NOP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            kij_r  <= '0;
            onij_r <= '0;
            inst   <= NOP;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            kij_r  <= kij_n;
            onij_r <= onij_n;
            inst   <= inst_n;
            busy   <= (state_n != S_IDLE);
            done   <= done_n;
            err    <= err_n;
        end
    end
endmodule

// File: tb/tb_inst_sequencer.sv
// tb/tb_inst_sequencer.sv - self-checking bench for inst_sequencer
module tb_inst_sequencer;
    localparam int COL = 8, ROW = 8, LEN_NIJ = 36, LEN_KIJ = 9, GAP = 10;
    localparam int OFW = (COL + 1) + COL + GAP + (LEN_NIJ + 1) + (LEN_NIJ + ROW + COL);

    typedef struct packed {
        logic        acc;
        logic        cen_p;
        logic        wen_p;
        logic [10:0] a_p;
        logic        cen_x;
        logic        wen_x;
        logic [10:0] a_x;
        logic        of_rd;
        logic        if_wr;
        logic        if_rd;
        logic        l0_rd;
        logic        l0_wr;
        logic        exe;
        logic        ld;
    } inst_t;

    logic        clk = 1'b0;
    logic        reset, start_kij, start_acc, ofifo_valid;
    logic [3:0]  kij, onij;
    logic [33:0] inst;
    logic        busy, done, err;
    int          n_vec = 0, n_err = 0;
    inst_t       exp_q[$];

    always #5 clk = ~clk;

    inst_sequencer #(.col(COL), .row(ROW), .len_nij(LEN_NIJ), .len_kij(LEN_KIJ), .gap(GAP)) dut (
        .clk(clk), .reset(reset), .start_kij(start_kij), .start_acc(start_acc),
        .kij(kij), .onij(onij), .ofifo_valid(ofifo_valid),
        .inst(inst), .busy(busy), .done(done), .err(err)
    );

    function automatic inst_t nop();
        inst_t w = '0;
        w.cen_p = 1'b1; w.wen_p = 1'b1; w.cen_x = 1'b1; w.wen_x = 1'b1;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic build_kij(input int k, input int hold);
        inst_t w;
        exp_q.delete();
        for (int i = 0; i <= COL; i++) begin
            w = nop(); w.cen_x = 1'b0; w.a_x = 11'(1024 + i); w.l0_wr = (i > 0); exp_q.push_back(w);
        end
        for (int i = 0; i < COL; i++) begin
            w = nop(); w.l0_rd = 1'b1; w.ld = 1'b1; exp_q.push_back(w);
        end
        for (int i = 0; i < GAP; i++) exp_q.push_back(nop());
        for (int i = 0; i <= LEN_NIJ; i++) begin
            w = nop(); w.cen_x = 1'b0; w.a_x = 11'(i); w.l0_wr = (i > 0); exp_q.push_back(w);
        end
        for (int i = 0; i < LEN_NIJ + ROW + COL; i++) begin
            w = nop(); w.exe = 1'b1; w.l0_rd = (i < LEN_NIJ); exp_q.push_back(w);
        end
        for (int i = 0; i <= hold; i++) exp_q.push_back(nop());
        for (int i = 0; i < LEN_NIJ; i++) begin
            w = nop(); w.of_rd = 1'b1; w.cen_p = 1'b0; w.wen_p = 1'b0;
            w.a_p = 11'(k * LEN_NIJ + i); exp_q.push_back(w);
        end
    endtask

    // Tap (kr,kc) contributes the psum stored at input pixel (r+kr, c+kc) of its own tap bank
    task automatic build_acc(input int o);
        inst_t w;
        int    r, c;
        r = o / 4; c = o % 4;
        exp_q.delete();
        for (int kr = 0; kr < 3; kr++)
            for (int kc = 0; kc < 3; kc++) begin
                w = nop(); w.cen_p = 1'b0;
                w.a_p = 11'((kr * 3 + kc) * LEN_NIJ + (r + kr) * 6 + (c + kc));
                w.acc = (kr + kc) > 0;
                exp_q.push_back(w);
            end
        w = nop(); w.acc = 1'b1; exp_q.push_back(w);
    endtask

    task automatic run_pass(input string tag, input int hold, input bit noise, input int stop_at);
        for (int i = 0; i < exp_q.size() && i < stop_at; i++) begin
            chk($sformatf("%s[%0d]", tag, i), {inst, busy, done, err}, {exp_q[i], 3'b100});
            ofifo_valid = (hold == 0) || (i >= OFW + hold);
            if (noise) begin
                start_kij = ($urandom_range(0, 5) == 0);
                start_acc = ($urandom_range(0, 5) == 0);
                kij       = 4'($urandom);
                onij      = 4'($urandom);
            end
            tick();
        end
        start_kij = 1'b0;
        start_acc = 1'b0;
        if (stop_at >= exp_q.size()) begin
            chk({tag, " done"}, {inst, busy, done, err}, {nop(), 3'b010});
            tick();
            chk({tag, " idle"}, {inst, busy, done, err}, {nop(), 3'b000});
        end
    endtask

    task automatic go_kij(input int k, input bit also_acc);
        kij = 4'(k); start_kij = 1'b1; start_acc = also_acc; onij = 4'($urandom);
        tick();
        start_kij = 1'b0; start_acc = 1'b0;
    endtask

    task automatic go_acc(input int o);
        onij = 4'(o); start_acc = 1'b1; kij = 4'($urandom);
        tick();
        start_acc = 1'b0;
    endtask

    initial begin
        int k, o, h;
        reset = 1'b1; start_kij = 1'b0; start_acc = 1'b0; kij = '0; onij = '0; ofifo_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", {inst, busy, done, err}, {nop(), 3'b000});
        reset = 1'b0;

        build_kij(2, 0); go_kij(2, 0); run_pass("kij2", 0, 0, 1 << 20);
        build_acc(5);    go_acc(5);    run_pass("acc5", 0, 1, 1 << 20);

        for (int n = 0; n < 4; n++) begin
            kij = 4'($urandom_range(9, 15)); start_kij = 1'b1; start_acc = 1'($urandom);
            tick();
            start_kij = 1'b0; start_acc = 1'b0;
            chk("err_pulse", {inst, busy, done, err}, {nop(), 3'b001});
            tick();
            chk("err_clear", {inst, busy, done, err}, {nop(), 3'b000});
        end

        k = $urandom_range(0, 8);
        build_kij(k, 0); go_kij(k, 1); run_pass("both", 0, 0, 1 << 20);
        repeat (3) begin
            tick();
            chk("both_no_acc", {inst, busy, done, err}, {nop(), 3'b000});
        end

        k = $urandom_range(0, 8);
        build_kij(k, 20); go_kij(k, 0); run_pass("ofwait", 20, 0, 1 << 20);

        build_kij(5, 0); go_kij(5, 0); run_pass("pre_rst", 0, 0, OFW - 10);
        reset = 1'b1;
        #1;
        chk("rst_mid", {inst, busy, done, err}, {nop(), 3'b000});
        @(negedge clk);
        reset = 1'b0;
        build_kij(0, 0); go_kij(0, 0); run_pass("kij0", 0, 0, 1 << 20);

        for (int n = 0; n < 3; n++) begin
            k = $urandom_range(0, 8); h = $urandom_range(0, 3);
            build_kij(k, h); go_kij(k, 0); run_pass($sformatf("rk%0d", k), h, 1, 1 << 20);
        end
        for (int n = 0; n < 4; n++) begin
            o = $urandom_range(0, 15);
            build_acc(o); go_acc(o); run_pass($sformatf("ra%0d", o), 0, 1, 1 << 20);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
